rriot_io: RTL

Parallel I/O port stage of the RRIOT core. It provides two 8-bit bidirectional ports, A and B, each with an output register and a data-direction register. It adds a PA7 edge-detect interrupt and sits directly downstream of the interval timer. It consumes the timer's active-low IRQ, merges it with the PA7 interrupt, and can drive the merged IRQ onto PB7 as an open-drain output.

---
 rtl/rriot_pkg.sv | 15 +
 rtl/rriot_io_sync.sv | 30 +++
 rtl/rriot_io.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rriot_pkg.sv
// Shared constants for the RRIOT core: register address map and ECR bit positions.
// Used by the parallel I/O stage and the interval timer.
package rriot_pkg;

    localparam logic [2:0] ADDR_ORA  = 3'b000;
    localparam logic [2:0] ADDR_DDRA = 3'b001;
    localparam logic [2:0] ADDR_ORB  = 3'b010;
    localparam logic [2:0] ADDR_DDRB = 3'b011;
    localparam logic [2:0] ADDR_ECR  = 3'b100;
    localparam logic [2:0] ADDR_IFR  = 3'b101;

    localparam int ECR_POL = 0;  // 1 = rising edge on PA7
    localparam int ECR_IE  = 1;  // PA7 interrupt enable

endpackage

// File: rtl/rriot_io_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs.
// The output is the input as sampled STAGES clock edges earlier.
module io_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/rriot_io.sv
// RRIOT parallel I/O stage: ports A/B with direction registers, PA7 edge interrupt,
// and merge of the timer IRQ, optionally driven open-drain onto PB7.
module rriot_io
    import rriot_pkg::*;
#(
    parameter int PB7_IRQ     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we_n,
    input  logic [2:0] A,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       OE,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    input  logic       timer_irq_n,
    output logic       irq_n
);

    // Bus access: a transfer occurs on every posedge where cs=1; there is no
    // ready, so back-to-back accesses never stall. Read data is valid (OE=1)
    // for exactly the one cycle following the sampling edge.

    logic [7:0] r_ora, r_ddra, r_orb, r_ddrb;
    logic [1:0] r_ecr;
    logic       r_pa7_prev, r_pa7_flag, r_irq_n, r_oe;
    logic [7:0] r_do;

    logic [7:0] w_pa_sync, w_pb_sync;
    logic [7:0] w_rd_data;
    logic       w_wr, w_rd, w_flag_set, w_flag_clr, w_pb7_irq, w_irq_n_next;

    io_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .i_d (pa_in),
        .o_q (w_pa_sync)
    );

    io_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .i_d (pb_in),
        .o_q (w_pb_sync)
    );

    assign w_wr = cs & ~we_n;
    assign w_rd = cs & we_n;

    always_comb begin
        w_rd_data = 8'h00;
        case (A)
            ADDR_ORA:  w_rd_data = (r_ddra & r_ora) | (~r_ddra & w_pa_sync);
            ADDR_DDRA: w_rd_data = r_ddra;
            ADDR_ORB:  w_rd_data = (r_ddrb & r_orb) | (~r_ddrb & w_pb_sync);
            ADDR_DDRB: w_rd_data = r_ddrb;
            ADDR_ECR:  w_rd_data = {6'd0, r_ecr};
            ADDR_IFR:  w_rd_data = {~timer_irq_n, r_pa7_flag, 6'd0};
            default:   w_rd_data = 8'h00;
        endcase
    end

    // Only true level changes of the synchronised pin count, so a polarity
    // write alone can never raise the flag.
    assign w_flag_set = r_ecr[ECR_POL] ? ( w_pa_sync[7] & ~r_pa7_prev)
                                       : (~w_pa_sync[7] &  r_pa7_prev);
    assign w_flag_clr = w_rd && (A == ADDR_IFR);
    assign w_irq_n_next = ~((r_pa7_flag & r_ecr[ECR_IE]) | ~timer_irq_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ora      <= 8'h00;
            r_ddra     <= 8'h00;
            r_orb      <= 8'h00;
            r_ddrb     <= 8'h00;
            r_ecr      <= 2'b00;
            r_pa7_prev <= 1'b0;
            r_pa7_flag <= 1'b0;
            r_irq_n    <= 1'b1;
            r_oe       <= 1'b0;
            r_do       <= 8'h00;
        end else begin
            if (w_wr) begin
                case (A)
                    ADDR_ORA:  r_ora  <= DI;
                    ADDR_DDRA: r_ddra <= DI;
                    ADDR_ORB:  r_orb  <= DI;
                    ADDR_DDRB: r_ddrb <= DI;
                    ADDR_ECR:  r_ecr  <= DI[1:0];
                    default:   ;
                endcase
            end
            r_oe <= w_rd;
            if (w_rd) begin
                r_do <= w_rd_data;
            end
            // Set has priority over a same-cycle clear.
            r_pa7_flag <= w_flag_set | (r_pa7_flag & ~w_flag_clr);
            r_pa7_prev <= w_pa_sync[7];
            r_irq_n    <= w_irq_n_next;
        end
    end

    assign w_pb7_irq = (PB7_IRQ != 0) && !r_ddrb[7];

    assign DO     = r_do;
    assign OE     = r_oe;
    assign irq_n  = r_irq_n;
    assign pa_out = r_ora;
    assign pa_oe  = r_ddra;
    assign pb_out = w_pb7_irq ? {1'b0, r_orb[6:0]} : r_orb;
    assign pb_oe  = w_pb7_irq ? {~r_irq_n, r_ddrb[6:0]} : r_ddrb;

endmodule
